// File: rtl/char_pixel_pipe_if.sv
// Pixel-stream bundle between the text fetch logic and char_pixel_pipe.
// The master drives glyph/attribute/palette inputs; the slave returns RGB and DE.
interface char_pixel_pipe_if #(
  parameter int CHAR_W = 8,
  parameter int PW     = (CHAR_W <= 8) ? 3 : 4,
  parameter int RW     = 3,
  parameter int GW     = 3,
  parameter int BW     = 2
);
  logic [CHAR_W-1:0]     DATA;
  logic [7:0]            ATTR;
  logic [PW-1:0]         PIXEL;
  logic                  BLANK;
  logic                  CURSOR;
  logic                  CURSOR_EN;
  logic                  FRAME;
  logic                  PAL_WE;
  logic [3:0]            PAL_ADDR;
  logic [RW+GW+BW-1:0]   PAL_DATA;
  logic [RW-1:0]         RED;
  logic [GW-1:0]         GREEN;
  logic [BW-1:0]         BLUE;
  logic                  DE;

  modport master (
    output DATA, ATTR, PIXEL, BLANK, CURSOR, CURSOR_EN, FRAME,
           PAL_WE, PAL_ADDR, PAL_DATA,
    input  RED, GREEN, BLUE, DE
  );

  modport slave (
    input  DATA, ATTR, PIXEL, BLANK, CURSOR, CURSOR_EN, FRAME,
           PAL_WE, PAL_ADDR, PAL_DATA,
    output RED, GREEN, BLUE, DE
  );
endinterface

// File: rtl/char_pixel_pipe.sv
// Two-stage character-cell pixel generator: glyph bit + attribute -> palette index,
// then palette lookup to registered RGB with aligned display enable.
module char_pixel_pipe #(
  parameter int CHAR_W    = 8,
  parameter int PW        = (CHAR_W <= 8) ? 3 : 4,
  parameter int RW        = 3,
  parameter int GW        = 3,
  parameter int BW        = 2,
  parameter int BLINK_EN  = 1,
  parameter int BLINK_DIV = 16
) (
  input logic               PIXCLK,
  input logic               RESET,
  char_pixel_pipe_if.slave  bus
);

  localparam int CW    = RW + GW + BW;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  // mode: 0 = off, 1 = dim (1010.. from MSB), 2 = full, 3 = grey (0101.. from MSB)
  function automatic logic [7:0] comp_val(input int w, input int mode);
    logic [7:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < w) begin
        case (mode)
          1:       v[b] = ((w - 1 - b) % 2 == 0);
          2:       v[b] = 1'b1;
          3:       v[b] = ((w - 1 - b) % 2 == 1);
          default: v[b] = 1'b0;
        endcase
      end
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] pal_default(input int i);
    logic [3:0] iv;
    logic [7:0] r, g, b;
    int         on_mode;
    iv      = 4'(i);
    on_mode = iv[3] ? 2 : 1;
    if (iv == 4'd8) begin
      r = comp_val(RW, 3);
      g = comp_val(GW, 3);
      b = comp_val(BW, 3);
    end else begin
      r = comp_val(RW, iv[1] ? on_mode : 0);
      g = comp_val(GW, iv[2] ? on_mode : 0);
      b = comp_val(BW, iv[0] ? on_mode : 0);
    end
    return {r[RW-1:0], g[GW-1:0], b[BW-1:0]};
  endfunction

  logic [CW-1:0]      pal_q [16];
  logic [(1<<PW)-1:0] col_bits;
  logic [CNT_W-1:0]   cnt_reg;
  logic               bp_reg;
  logic [3:0]         idx1_reg;
  logic               blank1_reg;
  logic [CW-1:0]      rgb_reg;
  logic               de_reg;
  logic [3:0]         idx_next;
  logic [3:0]         fg_idx, bg_idx, fg_blink, fg_eff, bg_eff;
  logic               blink, pix_bit;

  genvar gi;

  // Palette entries are individual registers so reset can restore the defaults.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pal
      localparam logic [CW-1:0] DEF = pal_default(gi);
      logic [CW-1:0] entry_reg;
      always_ff @(posedge PIXCLK or posedge RESET) begin
        if (RESET)
          entry_reg <= DEF;
        else if (bus.PAL_WE && bus.PAL_ADDR == 4'(gi))
          entry_reg <= bus.PAL_DATA;
      end
      assign pal_q[gi] = entry_reg;
    end

    // Column-ordered glyph bits; columns past the glyph width read as background.
    for (gi = 0; gi < (1 << PW); gi++) begin : g_col
      if (gi < CHAR_W) begin : g_in
        assign col_bits[gi] = bus.DATA[CHAR_W-1-gi];
      end else begin : g_pad
        assign col_bits[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    pix_bit  = col_bits[bus.PIXEL];
    fg_idx   = bus.ATTR[7:4];
    bg_idx   = (BLINK_EN != 0) ? {1'b0, bus.ATTR[2:0]} : bus.ATTR[3:0];
    blink    = (BLINK_EN != 0) && bus.ATTR[3];
    fg_blink = (blink && bp_reg) ? bg_idx : fg_idx;
    // Cursor swap follows blink, so a hidden blinking cursor cell is solid background.
    if (bus.CURSOR && bus.CURSOR_EN && bp_reg) begin
      fg_eff = bg_idx;
      bg_eff = fg_blink;
    end else begin
      fg_eff = fg_blink;
      bg_eff = bg_idx;
    end
    idx_next = pix_bit ? fg_eff : bg_eff;
  end

  always_ff @(posedge PIXCLK or posedge RESET) begin
    if (RESET) begin
      cnt_reg <= '0;
      bp_reg  <= 1'b0;
    end else if (bus.FRAME) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        bp_reg  <= ~bp_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge PIXCLK or posedge RESET) begin
    if (RESET) begin
      idx1_reg   <= '0;
      blank1_reg <= 1'b1;
      rgb_reg    <= '0;
      de_reg     <= 1'b0;
    end else begin
      idx1_reg   <= idx_next;
      blank1_reg <= bus.BLANK;
      rgb_reg    <= blank1_reg ? '0 : pal_q[idx1_reg];
      de_reg     <= ~blank1_reg;
    end
  end

  assign bus.RED   = rgb_reg[CW-1 -: RW];
  assign bus.GREEN = rgb_reg[BW+GW-1 -: GW];
  assign bus.BLUE  = rgb_reg[BW-1:0];
  assign bus.DE    = de_reg;

endmodule

// File: tb/tb_char_pixel_pipe.sv
// Directed bench for char_pixel_pipe: an 8-wide instance carries the main sequence,
// a 9-wide instance covers the ninth glyph column and out-of-glyph columns.
module tb_char_pixel_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  char_pixel_pipe_if #(.CHAR_W(8)) bus ();
  char_pixel_pipe_if #(.CHAR_W(9)) bus9 ();

  char_pixel_pipe #(.CHAR_W(8), .BLINK_DIV(2)) dut (
    .PIXCLK (clk),
    .RESET  (rst),
    .bus    (bus)
  );

  char_pixel_pipe #(.CHAR_W(9), .BLINK_DIV(2)) dut9 (
    .PIXCLK (clk),
    .RESET  (rst),
    .bus    (bus9)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] defs [16] = '{8'h00, 8'h02, 8'hA0, 8'hA2, 8'h14, 8'h16, 8'hB4, 8'hB6,
                            8'h49, 8'h03, 8'hE0, 8'hE3, 8'h1C, 8'h1F, 8'hFC, 8'hFF};

  // Two-deep queue of hand-written expectations matching the pipeline latency.
  logic       e1_v, e2_v;
  logic [8:0] e1_x, e2_x, n_x;
  string      e1_tag, e2_tag, n_tag;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed de/rgb=%h expected=%h", tag, obs, exp);
    end
    $display("xfer %s de/rgb=%h", tag, obs);
  endtask

  function automatic logic [8:0] obs_main();
    return {bus.DE, bus.RED, bus.GREEN, bus.BLUE};
  endfunction

  function automatic logic [8:0] obs9();
    return {bus9.DE, bus9.RED, bus9.GREEN, bus9.BLUE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    e2_v = e1_v; e2_x = e1_x; e2_tag = e1_tag;
    e1_v = 1'b1; e1_x = n_x;  e1_tag = n_tag;
    if (e2_v) chk(e2_tag, obs_main(), e2_x);
  endtask

  // Right after reset the stage-1 register holds blank, so the next output is 0/0.
  task automatic reset_pipe();
    e1_v = 1'b1; e1_x = 9'h000; e1_tag = "post_reset";
    e2_v = 1'b0;
  endtask

  task automatic drive(input logic [7:0] data, input logic [7:0] attr, input logic [2:0] pixel,
                       input logic blank, input logic [7:0] exp_rgb, input string tag);
    bus.DATA  = data;
    bus.ATTR  = attr;
    bus.PIXEL = pixel;
    bus.BLANK = blank;
    n_x   = {~blank, exp_rgb};
    n_tag = tag;
  endtask

  task automatic check9(input logic [8:0] data, input logic [3:0] pixel,
                        input logic [7:0] exp_rgb, input string tag);
    bus9.DATA  = data;
    bus9.ATTR  = 8'hF1;
    bus9.PIXEL = pixel;
    bus9.BLANK = 1'b0;
    drive(8'h00, 8'h00, 3'd0, 1'b1, 8'h00, "idle");
    tick();
    tick();
    chk(tag, obs9(), {1'b1, exp_rgb});
  endtask

  initial begin
    e1_v = 1'b0; e2_v = 1'b0; e1_x = '0; e2_x = '0; n_x = '0;
    drive(8'h00, 8'h00, 3'd0, 1'b1, 8'h00, "idle");
    bus.CURSOR = 0; bus.CURSOR_EN = 0; bus.FRAME = 0;
    bus.PAL_WE = 0; bus.PAL_ADDR = '0; bus.PAL_DATA = '0;
    bus9.DATA = '0; bus9.ATTR = '0; bus9.PIXEL = '0; bus9.BLANK = 1'b1;
    bus9.CURSOR = 0; bus9.CURSOR_EN = 0; bus9.FRAME = 0;
    bus9.PAL_WE = 0; bus9.PAL_ADDR = '0; bus9.PAL_DATA = '0;

    // Reset state, then release between edges
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", obs_main(), 9'h000);
    #2 rst = 1'b0;
    reset_pipe();

    // Default palette sweep through foreground index
    for (int i = 0; i < 16; i++) begin
      drive(8'hFF, 8'((i << 4)), 3'd0, 1'b0, defs[i], $sformatf("default_fg%0d", i));
      tick();
    end

    // Pixel order: leftmost set, rest background
    for (int p = 0; p < 8; p++) begin
      drive(8'h80, 8'hF1, 3'(p), 1'b0, (p == 0) ? 8'hFF : 8'h02, $sformatf("pix_order%0d", p));
      tick();
    end

    // Blanking window of three cycles
    drive(8'hFF, 8'hFF, 3'd0, 1'b0, 8'hFF, "pre_blank"); tick();
    for (int b = 0; b < 3; b++) begin
      drive(8'hFF, 8'hFF, 3'd0, 1'b1, 8'h00, $sformatf("blank%0d", b));
      tick();
    end
    drive(8'hFF, 8'hFF, 3'd0, 1'b0, 8'hFF, "post_blank"); tick();

    // Palette write while streaming background index 4
    drive(8'h00, 8'h04, 3'd0, 1'b0, 8'h14, "pal_old"); tick();
    bus.PAL_WE = 1; bus.PAL_ADDR = 4'd4; bus.PAL_DATA = 8'b110_001_01;
    drive(8'h00, 8'h04, 3'd0, 1'b0, 8'hC5, "pal_new0"); tick();
    bus.PAL_WE = 0;
    drive(8'h00, 8'h04, 3'd0, 1'b0, 8'hC5, "pal_new1"); tick();

    // Blink: BLINK_DIV=2, phase flips on the second FRAME; that edge still sees old phase
    drive(8'hFF, 8'hC9, 3'd0, 1'b0, 8'h1C, "blink_pre"); tick();
    bus.FRAME = 1; drive(8'hFF, 8'hC9, 3'd0, 1'b0, 8'h1C, "blink_f1"); tick();
    bus.FRAME = 0; drive(8'hFF, 8'hC9, 3'd0, 1'b0, 8'h1C, "blink_mid"); tick();
    bus.FRAME = 1; drive(8'hFF, 8'hC9, 3'd0, 1'b0, 8'h1C, "blink_f2_old"); tick();
    bus.FRAME = 0; drive(8'hFF, 8'hC9, 3'd0, 1'b0, 8'h02, "blink_hidden"); tick();
    drive(8'h00, 8'hC9, 3'd0, 1'b0, 8'h02, "blink_bgpix"); tick();

    // Cursor swap in phase 1
    bus.CURSOR = 1; bus.CURSOR_EN = 1;
    drive(8'h80, 8'hC1, 3'd0, 1'b0, 8'h02, "cursor_set"); tick();
    drive(8'h80, 8'hC1, 3'd1, 1'b0, 8'h1C, "cursor_clr"); tick();
    drive(8'h80, 8'hC9, 3'd0, 1'b0, 8'h02, "cur_blink_set"); tick();
    drive(8'h80, 8'hC9, 3'd1, 1'b0, 8'h02, "cur_blink_clr"); tick();
    bus.CURSOR_EN = 0;
    drive(8'h80, 8'hC1, 3'd0, 1'b0, 8'h1C, "cursor_off_set"); tick();
    drive(8'h80, 8'hC1, 3'd1, 1'b0, 8'h02, "cursor_off_clr"); tick();
    bus.CURSOR = 0;

    // Asynchronous reset during active video
    #2 rst = 1'b1;
    #1 chk("async_reset_out", obs_main(), 9'h000);
    #1 rst = 1'b0;
    reset_pipe();
    drive(8'hFF, 8'hC9, 3'd0, 1'b0, 8'h1C, "bp_cleared"); tick();
    drive(8'hFF, 8'h40, 3'd0, 1'b0, 8'h14, "pal_reverted_fg"); tick();
    drive(8'h00, 8'h04, 3'd0, 1'b0, 8'h14, "pal_reverted_bg"); tick();
    drive(8'h00, 8'h00, 3'd0, 1'b1, 8'h00, "idle"); tick();
    tick();

    // Nine-wide glyph: ninth column and columns beyond the glyph
    check9(9'h100, 4'd0,  8'hFF, "w9_col0");
    check9(9'h001, 4'd8,  8'hFF, "w9_col8_set");
    check9(9'h1FE, 4'd8,  8'h02, "w9_col8_clr");
    check9(9'h1FF, 4'd12, 8'h02, "w9_col12_out");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
